seven_seg_reader: RTL
=====================

SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical samples required before a capture; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg_n  input  7  active-low segment lines: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 SHALL have port dig_en  input  4  one-hot digit select of the multiplexed display; bit i selects digit i.
REQ-006 SHALL have port digits  output  16  captured hex values; digits[4i+3:4i] belongs to digit i.
REQ-007 SHALL have port digit_valid  output  4  bit i high when digit i holds a decoded value.
REQ-008 SHALL have port upd  output  1  one-cycle pulse on every capture.
REQ-009 SHALL have port upd_idx  output  2  index of the captured digit; meaningful only while upd=1.
REQ-010 SHALL have port err  output  1  one-cycle pulse when a captured pattern is not a legal glyph.
REQ-011 SHALL have port err_count  output  8  count of err pulses, saturating at 255.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse.

Function
REQ-013 SHALL register seg_n and dig_en through one input stage before any comparison.
REQ-014 SHALL treat a sample as qualified only when dig_en is exactly one-hot; a zero or multi-hot dig_en SHALL clear the stability counter and prevent capture.
REQ-015 SHALL increment an 8-bit stability counter when the qualified sample equals the previous sample; a differing sample SHALL reload it to 1.
REQ-016 SHALL capture exactly once per stable run, when the counter first reaches STABLE_CYCLES; it SHALL not capture again until the sample changes.
REQ-017 SHALL make captured results visible after edge E+STABLE_CYCLES, where E is the first edge that samples the new input.
REQ-018 SHALL decode active-high segment patterns (~seg_n) as follows: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001 (bits g..a).
REQ-019 On a legal-glyph capture, SHALL write the value into digit i, set digit_valid[i], and pulse upd with upd_idx=i.
REQ-020 On a blank capture (seg_n=7'h7F), SHALL clear digit_valid[i], leave digits unchanged, pulse upd, and not assert err.
REQ-021 On any other pattern, SHALL clear digit_valid[i], leave digits unchanged, pulse upd and err, and increment err_count unless it is already 255.
REQ-022 SHALL keep a 4-bit seen mask that sets bit i on every capture of digit i; when the mask becomes 4'hF, it SHALL pulse frame_done in the same cycle as that upd and clear the mask.
REQ-023 SHALL hold all outputs stable between captures; upd, err, and frame_done SHALL never exceed one cycle per capture.

Reset
REQ-024 While rst=1 at a clock edge, SHALL clear digits, digit_valid, upd, upd_idx, err, err_count, frame_done, the seen mask, and the stability counter to 0, and SHALL clear the input registers to dig_en=0 and seg_n=7'h7F.
REQ-025 Reset mid-run SHALL discard any partial count; the first capture after release SHALL require a full STABLE_CYCLES run.

Structure
REQ-026 The 16 glyph pattern constants and the blank constant SHALL live in shared package seg7_pkg, so the existing encoder can reuse them.
REQ-027 SHALL instantiate one combinational sub-module, seg7_pattern_decode, mapping a 7-bit pattern to {legal, blank, value[3:0]}.

Verification
REQ-028 SHALL cover: dig_en=0001 and seg_n=~1011011 held 6 cycles -> digits[3:0]=2, digit_valid=0001, one upd with upd_idx=0.
REQ-029 SHALL cover: the digit-5 pattern held 3 cycles, then changed -> no upd; the new pattern held 4 cycles -> single capture of the new value.
REQ-030 SHALL cover: dig_en=0010 and seg_n=~0000001 stable -> err pulse, err_count=1, digit_valid[1]=0, digits[7:4] unchanged.
REQ-031 SHALL cover: scanning A, b, C, d on digits 0..3, each held 5 cycles -> digits=16'hDCBA, digit_valid=1111, frame_done pulsed once with the fourth upd.
REQ-032 SHALL cover: dig_en=0011 held 20 cycles -> no upd, no err.
REQ-033 SHALL cover: rst pulsed while the counter is at 3 -> all outputs 0; capture occurs only 4 stable samples after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared seven-segment definitions. These are used by the reader and by the
// existing encoder.
//   - Active-high glyph patterns for hex digits 0..F. Bit order is g..a
//     (bit6 = g, bit0 = a).
//   - Blank constants in both polarities.
//   - Decode result struct and small one-hot helpers for the digit select.
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Blank display: all segments off.
  localparam logic [6:0] SEG_BLANK_N = 7'h7F;  // as seen on active-low lines
  localparam logic [6:0] SEG_BLANK   = 7'h00;  // active-high form

  // Active-high glyphs, bits g..a
  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1100111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  // Indexed by hex value: GLYPH_TABLE[v] is the glyph for value v.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } seg7_decode_t;

  // True when exactly one bit of a 4-bit select is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Index of the set bit. The result only matters for one-hot inputs.
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational decode of an active-high 7-segment pattern (bits g..a).
// Ports:
//   pattern_i  in  7  active-high segment pattern
//   legal_o    out 1  pattern is one of the 16 hex glyphs
//   blank_o    out 1  pattern has no segments lit
//   value_o    out 4  hex value of the glyph (0 when not legal)
// -----------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] value_o
);

  always_comb begin
    legal_o = 1'b0;
    value_o = 4'd0;
    blank_o = (pattern_i == SEG_BLANK);
    // The glyphs are all distinct, so at most one entry can match.
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern_i == GLYPH_TABLE[i]) begin
        legal_o = 1'b1;
        value_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// -----------------------------------------------------------------------------
// seven_seg_reader
// Recovers hex digits from a multiplexed, active-low 4-digit seven-segment
// display bus. A digit is captured once its pattern has been stable for
// STABLE_CYCLES consecutive qualified samples.
// Ports:
//   clk          in  1   clock; all state changes on the rising edge
//   rst          in  1   synchronous active-high reset
//   seg_n        in  7   active-low segments, bit0=a .. bit6=g
//   dig_en       in  4   one-hot digit select
//   digits       out 16  captured values; digits[4i+3:4i] belongs to digit i
//   digit_valid  out 4   digit i holds a decoded value
//   upd          out 1   one-cycle pulse on each capture
//   upd_idx      out 2   digit index of the last capture
//   err          out 1   one-cycle pulse when the captured pattern is illegal
//   err_count    out 8   saturating count of err pulses
//   frame_done   out 1   one-cycle pulse once all four digits have been seen
// -----------------------------------------------------------------------------
module seven_seg_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_en,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err,
  output logic [7:0]  err_count,
  output logic        frame_done
);

  localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

  // Input stage and the sample taken one cycle earlier
  logic [6:0]  seg_q,  prev_seg_q;
  logic [3:0]  en_q,   prev_en_q;

  // Stability tracking and results
  logic [7:0]  cnt_q,  cnt_d;
  logic [15:0] digits_q;
  logic [3:0]  valid_q;
  logic        upd_q;
  logic [1:0]  upd_idx_q;
  logic        err_q;
  logic [7:0]  err_count_q, err_count_d;
  logic        frame_done_q;
  logic [3:0]  seen_q, seen_d;

  logic        qual;
  logic        same;
  logic        capture;
  logic        bad_glyph;
  logic [1:0]  idx;
  seg7_decode_t dec;

  seg7_pattern_decode u_decode (
    .pattern_i (~seg_q),
    .legal_o   (dec.legal),
    .blank_o   (dec.blank),
    .value_o   (dec.value)
  );

  // ---- Qualification and stability count ----
  always_comb begin
    qual = is_onehot4(en_q);
    same = (seg_q == prev_seg_q) && (en_q == prev_en_q);
    idx  = onehot4_to_idx(en_q);

    cnt_d = cnt_q;
    if (!qual) begin
      cnt_d = 8'd0;
    end else if (!same || (cnt_q == 8'd0)) begin
      cnt_d = 8'd1;
    end else if (cnt_q != 8'hFF) begin
      // Saturate at 255 so a long run can never wrap back onto the target.
      cnt_d = cnt_q + 8'd1;
    end

    // Capture only on the transition into the target count. This gives one
    // capture per stable run.
    capture   = qual && (cnt_d == STABLE_TARGET) && (cnt_q != STABLE_TARGET);
    bad_glyph = !dec.legal && !dec.blank;

    err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    seen_d      = seen_q | (4'b0001 << idx);
  end

  // ---- Registered state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= SEG_BLANK_N;
      en_q         <= 4'b0000;
      prev_seg_q   <= SEG_BLANK_N;
      prev_en_q    <= 4'b0000;
      cnt_q        <= 8'd0;
      digits_q     <= 16'h0000;
      valid_q      <= 4'b0000;
      upd_q        <= 1'b0;
      upd_idx_q    <= 2'd0;
      err_q        <= 1'b0;
      err_count_q  <= 8'd0;
      frame_done_q <= 1'b0;
      seen_q       <= 4'b0000;
    end else begin
      seg_q        <= seg_n;
      en_q         <= dig_en;
      prev_seg_q   <= seg_q;
      prev_en_q    <= en_q;
      cnt_q        <= cnt_d;

      upd_q        <= capture;
      err_q        <= capture && bad_glyph;
      frame_done_q <= capture && (seen_d == 4'hF);

      if (capture) begin
        upd_idx_q <= idx;
        if (dec.legal) begin
          digits_q[idx*4 +: 4] <= dec.value;
          valid_q[idx]         <= 1'b1;
        end else begin
          // Blank or illegal: the old value stays, but it is no longer valid.
          valid_q[idx] <= 1'b0;
        end
        if (bad_glyph) begin
          err_count_q <= err_count_d;
        end
        seen_q <= (seen_d == 4'hF) ? 4'b0000 : seen_d;
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign frame_done  = frame_done_q;

endmodule
